// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the fetch stage and its next-PC helper.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0;
  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_pkt_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux and sequential adder.
// Kept separate so decode can reuse the target selection.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc4_o,
  output logic [31:0] new_pc_o
);

  // Sequential PC wraps naturally at 32 bits.
  assign pc4_o    = pc_i + PC_INC;
  assign new_pc_o = redirect_i ? redirect_pc_i : pc4_o;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: memory handshake, skid buffer, IF/ID register.
// Optional IF_DELAY_SLOT_EN keeps the branch delay slot on redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] new_pc,
  output logic        PCwrite,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  fetch_pkt_t   skid_q, skid_d;
  logic         skid_vld_q, skid_vld_d;
  fetch_pkt_t   ifid_q, ifid_d;
  logic         ifid_vld_q, ifid_vld_d;
  logic [31:0]  pc4;
  fetch_pkt_t   fetched;

  next_pc_sel u_next_pc_sel (
    .pc_i          (pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc4_o         (pc4),
    .new_pc_o      (new_pc)
  );

  assign imem_addr = pc;
  assign fetched   = '{instr: imem_rdata, pc4: pc4};

  // Next-state, skid and IF/ID update; outputs idle while in reset.
  always_comb begin
    state_d    = state_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    ifid_d     = ifid_q;
    ifid_vld_d = ifid_vld_q;
    PCwrite    = 1'b0;
    imem_req   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (redirect) begin
            PCwrite = 1'b1;
`ifdef IF_DELAY_SLOT_EN
            if (imem_ready) begin
              ifid_d     = fetched;
              ifid_vld_d = 1'b1;
            end else begin
              ifid_vld_d = 1'b0;
            end
`else
            ifid_vld_d = 1'b0;
`endif
          end else if (stall) begin
            if (imem_ready) begin
              skid_d     = fetched;
              skid_vld_d = 1'b1;
              state_d    = HOLD;
            end
          end else if (imem_ready) begin
            PCwrite    = 1'b1;
            ifid_d     = fetched;
            ifid_vld_d = 1'b1;
          end else begin
            ifid_vld_d = 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            PCwrite    = 1'b1;
            skid_vld_d = 1'b0;
            state_d    = FETCH;
`ifdef IF_DELAY_SLOT_EN
            ifid_d     = skid_q;
            ifid_vld_d = 1'b1;
`else
            ifid_vld_d = 1'b0;
`endif
          end else if (!stall) begin
            PCwrite    = 1'b1;
            ifid_d     = skid_q;
            ifid_vld_d = 1'b1;
            skid_vld_d = 1'b0;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, skid buffer and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      skid_q     <= '{instr: NOP_INSTR, pc4: RESET_VECTOR};
      skid_vld_q <= 1'b0;
      ifid_q     <= '{instr: NOP_INSTR, pc4: RESET_VECTOR};
      ifid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      ifid_q     <= ifid_d;
      ifid_vld_q <= ifid_vld_d;
    end
  end

  assign if_id_valid = ifid_vld_q;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_instr = ifid_vld_q ? ifid_q.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a local PC register.
// Memory returns {A5, addr[23:0]}; garbage when not ready.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] new_pc;
  logic        PCwrite;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        ld;
  logic [31:0] ld_val;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_rdata = imem_ready ? mem(imem_addr) : 32'hDEADBEEF;

  always_ff @(posedge clk) begin
    if (ld) pc <= ld_val;
    else if (!rst_n) pc <= 32'h0;
    else if (PCwrite) pc <= new_pc;
  end

  if_fetch_stage #(
    .RESET_VECTOR (32'h0),
    .NOP_INSTR    (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .new_pc      (new_pc),
    .PCwrite     (PCwrite),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; ld_val = '0;
    imem_ready = 1'b0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    settle();
    chk("rst_pcw", {31'b0, PCwrite}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_vld", {31'b0, if_id_valid}, 32'd0);
    chk("rst_ins", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);

    rst_n = 1'b1; imem_ready = 1'b1;
    settle();
    chk("f0_req", {31'b0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_npc", new_pc, 32'd4);
    chk("f0_pcw", {31'b0, PCwrite}, 32'd1);
    tick();
    chk("f1_pc4", if_id_pc4, 32'd4);
    chk("f1_vld", {31'b0, if_id_valid}, 32'd1);
    chk("f1_ins", if_id_instr, mem(32'h0));
    chk("f1_npc", new_pc, 32'd8);
    tick();
    chk("f2_pc4", if_id_pc4, 32'd8);
    chk("f2_npc", new_pc, 32'd12);

    imem_ready = 1'b0;
    settle();
    chk("w0_pcw", {31'b0, PCwrite}, 32'd0);
    tick();
    chk("w1_vld", {31'b0, if_id_valid}, 32'd0);
    chk("w1_ins", if_id_instr, 32'h0);
    chk("w1_pcw", {31'b0, PCwrite}, 32'd0);
    tick();
    chk("w2_vld", {31'b0, if_id_valid}, 32'd0);
    imem_ready = 1'b1;
    settle();
    chk("w2_addr", imem_addr, 32'd8);
    chk("w2_pcw", {31'b0, PCwrite}, 32'd1);
    tick();
    chk("w3_pc4", if_id_pc4, 32'd12);
    chk("w3_ins", if_id_instr, mem(32'd8));

    stall = 1'b1;
    settle();
    chk("s0_pcw", {31'b0, PCwrite}, 32'd0);
    chk("s0_req", {31'b0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_req", {31'b0, imem_req}, 32'd0);
      chk("s_pcw", {31'b0, PCwrite}, 32'd0);
      chk("s_pc4", if_id_pc4, 32'd12);
      chk("s_ins", if_id_instr, mem(32'd8));
    end
    stall = 1'b0;
    settle();
    chk("sr_pcw", {31'b0, PCwrite}, 32'd1);
    chk("sr_npc", new_pc, 32'd16);
    tick();
    chk("sr_pc4", if_id_pc4, 32'd16);
    chk("sr_ins", if_id_instr, mem(32'd12));
    chk("sr_vld", {31'b0, if_id_valid}, 32'd1);
    chk("sr_addr", imem_addr, 32'd16);

    redirect = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("r0_npc", new_pc, 32'h100);
    chk("r0_pcw", {31'b0, PCwrite}, 32'd1);
    tick();
    redirect = 1'b0;
    settle();
`ifdef IF_DELAY_SLOT_EN
    chk("r1_vld", {31'b0, if_id_valid}, 32'd1);
    chk("r1_ins", if_id_instr, mem(32'd16));
    chk("r1_pc4", if_id_pc4, 32'd20);
`else
    chk("r1_vld", {31'b0, if_id_valid}, 32'd0);
    chk("r1_ins", if_id_instr, 32'h0);
`endif
    chk("r1_addr", imem_addr, 32'h100);

    stall = 1'b1;
    tick();
    chk("h0_req", {31'b0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    settle();
    chk("h0_pcw", {31'b0, PCwrite}, 32'd1);
    chk("h0_npc", new_pc, 32'h200);
    tick();
    redirect = 1'b0; stall = 1'b0;
    settle();
    chk("h1_req", {31'b0, imem_req}, 32'd1);
    chk("h1_addr", imem_addr, 32'h200);
`ifdef IF_DELAY_SLOT_EN
    chk("h1_vld", {31'b0, if_id_valid}, 32'd1);
    chk("h1_ins", if_id_instr, mem(32'h100));
    chk("h1_pc4", if_id_pc4, 32'h104);
`else
    chk("h1_vld", {31'b0, if_id_valid}, 32'd0);
`endif
    tick();
    chk("h2_pc4", if_id_pc4, 32'h204);
    chk("h2_ins", if_id_instr, mem(32'h200));

    ld = 1'b1; ld_val = 32'hFFFFFFFC;
    tick();
    ld = 1'b0;
    settle();
    chk("wr_addr", imem_addr, 32'hFFFFFFFC);
    chk("wr_npc", new_pc, 32'h0);
    chk("wr_pcw", {31'b0, PCwrite}, 32'd1);
    tick();
    chk("wr_pc4", if_id_pc4, 32'h0);
    chk("wr_ins", if_id_instr, mem(32'hFFFFFFFC));

    stall = 1'b1;
    tick();
    chk("rh_req", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b0;
    settle();
    chk("rh_pcw", {31'b0, PCwrite}, 32'd0);
    chk("rh_req0", {31'b0, imem_req}, 32'd0);
    tick();
    chk("rh_vld", {31'b0, if_id_valid}, 32'd0);
    chk("rh_ins", if_id_instr, 32'h0);
    chk("rh_pc4", if_id_pc4, 32'h0);
    rst_n = 1'b1; stall = 1'b0;
    settle();
    chk("ra_req", {31'b0, imem_req}, 32'd1);
    chk("ra_addr", imem_addr, 32'h0);
    tick();
    chk("ra_pc4", if_id_pc4, 32'd4);
    chk("ra_ins", if_id_instr, mem(32'h0));
    chk("ra_vld", {31'b0, if_id_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
